// File: rtl/prio_scan_encoder.sv
// prio_scan_encoder: captures a request vector and hands out the index of
// every set bit, one per valid/ready handshake, in priority order.
//
// Handshake rules: on the output side a transfer happens at a rising edge
// where op_valid=1 and out_ready=1; op/last/op_valid are held stable while
// op_valid=1 and out_ready=0. On the input side a capture happens at a rising
// edge where load=1 and in_ready=1; load is simply ignored otherwise.
module prio_scan_encoder #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  localparam int IDXW     = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            load,
  input  logic [WIDTH-1:0] a,
  output logic            in_ready,
  output logic [IDXW-1:0] op,
  output logic            op_valid,
  input  logic            out_ready,
  output logic            last,
  output logic            none,
  output logic [IDXW:0]   count,
  output logic            dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pending, pending_next;
  logic [IDXW:0]    count_next;
  logic             none_next;
  logic             single_bit;
  logic             capture;
  logic             handshake;

  // Priority encoding of the pending set; pending is zero in IDLE so op reads 0.
  always_comb begin
    op = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pending[i]) op = IDXW'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pending[i]) op = IDXW'(i);
      end
    end
  end

  // Next-state and handshake logic; a capture takes precedence over the drain
  // of the final bit so back-to-back vectors need no bubble.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    count_next   = count;
    none_next    = 1'b0;
    single_bit   = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);
    op_valid     = en & (state == SCAN);
    last         = (state == SCAN) & single_bit;
    in_ready     = en & ((state == IDLE) | (op_valid & out_ready & last));
    capture      = in_ready & load;
    handshake    = op_valid & out_ready;
    if (capture) begin
      count_next = '0;
      if (a != '0) begin
        pending_next = a;
        state_next   = SCAN;
      end else begin
        pending_next = '0;
        state_next   = IDLE;
        none_next    = 1'b1;
      end
    end else if (handshake) begin
      pending_next = pending & ~(WIDTH'(1) << op);
      count_next   = count + (IDXW + 1)'(1);
      if (last) state_next = IDLE;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      count   <= '0;
      none    <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      count   <= count_next;
      none    <= none_next;
    end
  end

  assign dbg_state = (state == SCAN);

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Bench for prio_scan_encoder: three instances (8-bit MSB-first, 8-bit
// LSB-first, 12-bit MSB-first) share control inputs. The driver pushes the
// expected index stream of each captured vector into a per-instance queue;
// a monitor on the falling edge compares every output and pops on transfers.
module tb_prio_scan_encoder;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic        out_ready;
  logic [7:0]  a8;
  logic [11:0] a12;

  logic        in_ready_m, in_ready_l, in_ready_w;
  logic [2:0]  op_m, op_l;
  logic [3:0]  op_w;
  logic        op_valid_m, op_valid_l, op_valid_w;
  logic        last_m, last_l, last_w;
  logic        none_m, none_l, none_w;
  logic [3:0]  count_m, count_l;
  logic [4:0]  count_w;
  logic        dbg_m, dbg_l, dbg_w;

  logic [3:0]  exp_q [3][$];
  int          total [3];
  bit          exp_none [3];
  bit          started;
  int          n_checks;
  int          n_errors;

  prio_scan_encoder #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .a(a8),
    .in_ready(in_ready_m), .op(op_m), .op_valid(op_valid_m),
    .out_ready(out_ready), .last(last_m), .none(none_m),
    .count(count_m), .dbg_state(dbg_m)
  );

  prio_scan_encoder #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .a(a8),
    .in_ready(in_ready_l), .op(op_l), .op_valid(op_valid_l),
    .out_ready(out_ready), .last(last_l), .none(none_l),
    .count(count_l), .dbg_state(dbg_l)
  );

  prio_scan_encoder #(.WIDTH(12), .MSB_FIRST(1)) u_wide (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .a(a12),
    .in_ready(in_ready_w), .op(op_w), .op_valid(op_valid_w),
    .out_ready(out_ready), .last(last_w), .none(none_w),
    .count(count_w), .dbg_state(dbg_w)
  );

  // Clock and reset-state defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: list of set-bit indices of v in service order.
  function automatic void push_vec(input int k, input int w, input bit msb, input logic [11:0] v);
    if (msb) begin
      for (int i = w - 1; i >= 0; i--) if (v[i]) exp_q[k].push_back(4'(i));
    end else begin
      for (int i = 0; i < w; i++) if (v[i]) exp_q[k].push_back(4'(i));
    end
  endfunction

  // Drives one cycle of inputs, then records the effect of the edge.
  task automatic drive_cycle(input logic r, input logic e, input logic l,
                             input logic [7:0] v8, input logic [11:0] v12, input logic o);
    bit          cap [3];
    logic [11:0] vec [3];
    rst_n     = r;
    en        = e;
    load      = l;
    a8        = v8;
    a12       = v12;
    out_ready = o;
    vec[0] = {4'h0, v8};
    vec[1] = {4'h0, v8};
    vec[2] = v12;
    for (int k = 0; k < 3; k++)
      cap[k] = l && e && (exp_q[k].size() == 0 || (o && exp_q[k].size() == 1));
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_none[k] = 1'b0;
      if (!r) begin
        exp_q[k].delete();
        total[k] = 0;
      end else if (cap[k]) begin
        if (vec[k] != '0) begin
          push_vec(k, (k == 2) ? 12 : 8, (k != 1), vec[k]);
          total[k] = $countones(vec[k]);
        end else begin
          total[k] = 0;
          exp_none[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int k, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s[%0d] @%0t: got %0d, expected %0d", name, k, $time, act, req);
    end
  endtask

  // Monitor: compares all outputs against the queue model, pops on transfers.
  always @(negedge clk) begin
    int  sz;
    int  act_op, act_cnt;
    bit  act_v, act_last, act_ir, act_none, act_dbg;
    bit  ev;
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        case (k)
          0: begin act_op = op_m; act_cnt = count_m; act_v = op_valid_m; act_last = last_m;
                   act_ir = in_ready_m; act_none = none_m; act_dbg = dbg_m; end
          1: begin act_op = op_l; act_cnt = count_l; act_v = op_valid_l; act_last = last_l;
                   act_ir = in_ready_l; act_none = none_l; act_dbg = dbg_l; end
          default: begin act_op = op_w; act_cnt = count_w; act_v = op_valid_w; act_last = last_w;
                   act_ir = in_ready_w; act_none = none_w; act_dbg = dbg_w; end
        endcase
        sz = exp_q[k].size();
        ev = en && sz > 0;
        chk("op_valid", k, int'(act_v), int'(ev));
        chk("op", k, act_op, (sz > 0) ? int'(exp_q[k][0]) : 0);
        chk("last", k, int'(act_last), int'(sz == 1));
        chk("in_ready", k, int'(act_ir), int'(en && (sz == 0 || (out_ready && sz == 1))));
        chk("none", k, int'(act_none), int'(exp_none[k]));
        chk("count", k, act_cnt, total[k] - sz);
        chk("state", k, int'(act_dbg), int'(sz > 0));
        if (rst_n && ev && out_ready) void'(exp_q[k].pop_front());
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic, then drain.
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    started   = 1'b0;
    rst_n     = 1'b0;
    en        = 1'b0;
    load      = 1'b0;
    out_ready = 1'b0;
    a8        = '0;
    a12       = '0;
    for (int k = 0; k < 3; k++) begin
      total[k] = 0;
      exp_none[k] = 1'b0;
    end
    // Reset held two cycles, then idle.
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h00, 12'h000, 1'b0);
    started = 1'b1;
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h00, 12'h000, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 12'h000, 1'b1);
    // Priority order drain of 1010_0110.
    drive_cycle(1'b1, 1'b1, 1'b1, 8'hA6, 12'h0A6, 1'b1);
    repeat (5) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 12'h000, 1'b1);
    // Backpressure, then enable stall, then resume.
    drive_cycle(1'b1, 1'b1, 1'b1, 8'h81, 12'h081, 1'b0);
    repeat (3) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 12'h000, 1'b0);
    repeat (2) drive_cycle(1'b1, 1'b0, 1'b1, 8'h0F, 12'h00F, 1'b1);
    repeat (3) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 12'h000, 1'b1);
    // Zero vector, then back-to-back capture on the final handshake.
    drive_cycle(1'b1, 1'b1, 1'b1, 8'h00, 12'h000, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 12'h000, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b1, 8'h01, 12'h001, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b1, 8'h10, 12'h010, 1'b1);
    repeat (2) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 12'h000, 1'b1);
    // All-ones, three transfers, ignored load during scan, reset mid-scan.
    drive_cycle(1'b1, 1'b1, 1'b1, 8'hFF, 12'hFFF, 1'b1);
    repeat (3) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 12'h000, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b1, 8'h55, 12'h555, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b1, 8'h33, 12'h333, 1'b1);
    repeat (2) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 12'h000, 1'b1);
    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      logic [7:0]  r8;
      logic [11:0] r12;
      r8  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      r12 = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
      drive_cycle(($urandom_range(0, 79) != 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 2) == 0), r8, r12, ($urandom_range(0, 3) != 0));
    end
    // Drain anything left.
    repeat (20) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 12'h000, 1'b1);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
